// File: rtl/conv2x2_stream_if.sv
// conv2x2_stream_if: load/result stream bundle; master drives in_valid/in_row/in_kernel, slave returns out_valid/out_data
interface conv2x2_stream_if #(
  parameter int PIX_W = 3,
  parameter int DIM = 6,
  parameter int OUT_W = 8
);
  logic in_valid;
  logic [DIM*PIX_W-1:0] in_row;
  logic [4*PIX_W-1:0] in_kernel;
  logic out_valid;
  logic [OUT_W-1:0] out_data;
  modport master (output in_valid, in_row, in_kernel, input out_valid, out_data);
  modport slave (input in_valid, in_row, in_kernel, output out_valid, out_data);
endinterface

// File: rtl/conv2x2_stream_engine.sv
// conv2x2_stream_engine: loads a DIMxDIM image plus DIM 2x2 kernels, then streams all valid 2x2 convolutions (ports: clk, rst, s = slave stream bundle)
module conv2x2_stream_engine #(
  parameter int PIX_W = 3,
  parameter int DIM = 6,
  parameter int OUT_W = 8
) (
  input logic clk,
  input logic rst,
  conv2x2_stream_if.slave s
);
  localparam int CW = $clog2(DIM);
  localparam int NOUT = DIM * (DIM - 1) * (DIM - 1);
  localparam int NW = $clog2(NOUT);
  localparam int PW = 2 * PIX_W;
  localparam logic [CW-1:0] LAST_RC = CW'(DIM - 2);
  localparam logic [CW-1:0] LAST_K = CW'(DIM - 1);
  typedef enum logic [1:0] {IDLE, LOAD, FILL, OUT} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] load_cnt_q, load_cnt_d, k_q, k_d, r_q, r_d, c_q, c_d;
  logic [NW-1:0] out_cnt_q, out_cnt_d;
  logic [DIM*PIX_W-1:0] img_q [DIM], img_d [DIM];
  logic [4*PIX_W-1:0] ker_q [DIM], ker_d [DIM];
  logic [PW-1:0] prod_q [4], prod_d [4];
  logic [OUT_W-1:0] sum, out_data_q, out_data_d;
  logic out_valid_q, out_valid_d, adv;
  always_comb begin
    sum = OUT_W'(prod_q[0]) + OUT_W'(prod_q[1]) + OUT_W'(prod_q[2]) + OUT_W'(prod_q[3]);
    for (int i = 0; i < 4; i++)
      prod_d[i] = PW'(img_q[r_q + CW'(i / 2)][(int'(c_q) + i % 2) * PIX_W +: PIX_W]) * PW'(ker_q[k_q][i * PIX_W +: PIX_W]);
    state_d = state_q;
    load_cnt_d = load_cnt_q;
    out_cnt_d = out_cnt_q;
    img_d = img_q;
    ker_d = ker_q;
    out_valid_d = 1'b0;
    out_data_d = '0;
    adv = 1'b0;
    case (state_q)
      IDLE: begin
        out_cnt_d = '0;
        if (s.in_valid) begin
          img_d[0] = s.in_row;
          ker_d[0] = s.in_kernel;
          load_cnt_d = CW'(1);
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (s.in_valid) begin
          img_d[load_cnt_q] = s.in_row;
          ker_d[load_cnt_q] = s.in_kernel;
          load_cnt_d = load_cnt_q + 1'b1;
          adv = load_cnt_q == LAST_K;
          state_d = load_cnt_q == LAST_K ? FILL : LOAD;
        end else
          state_d = IDLE;
      end
      FILL: begin
        state_d = OUT;
        adv = 1'b1;
        out_valid_d = 1'b1;
        out_data_d = sum;
        out_cnt_d = '0;
      end
      default: begin
        out_cnt_d = out_cnt_q + 1'b1;
        if (out_cnt_q == NW'(NOUT - 1))
          state_d = IDLE;
        else begin
          adv = 1'b1;
          out_valid_d = 1'b1;
          out_data_d = sum;
        end
      end
    endcase
    // product index leads the displayed index by one: it steps on entering FILL and every result cycle
    c_d = state_q == IDLE ? '0 : !adv ? c_q : c_q == LAST_RC ? '0 : c_q + 1'b1;
    r_d = state_q == IDLE ? '0 : !adv || c_q != LAST_RC ? r_q : r_q == LAST_RC ? '0 : r_q + 1'b1;
    k_d = state_q == IDLE ? '0 : !adv || c_q != LAST_RC || r_q != LAST_RC ? k_q : k_q == LAST_K ? '0 : k_q + 1'b1;
  end
  always_ff @(posedge clk) begin
    img_q <= img_d;
    ker_q <= ker_d;
    prod_q <= prod_d;
    if (rst) begin
      state_q <= IDLE;
      load_cnt_q <= '0;
      out_cnt_q <= '0;
      k_q <= '0;
      r_q <= '0;
      c_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q <= '0;
    end else begin
      state_q <= state_d;
      load_cnt_q <= load_cnt_d;
      out_cnt_q <= out_cnt_d;
      k_q <= k_d;
      r_q <= r_d;
      c_q <= c_d;
      out_valid_q <= out_valid_d;
      out_data_q <= out_data_d;
    end
  end
  assign s.out_valid = out_valid_q;
  assign s.out_data = out_data_q;
endmodule

// File: tb/tb_conv2x2_stream_engine.sv
// tb_conv2x2_stream_engine: table-driven and randomized frames checked against a direct convolution model
module tb_conv2x2_stream_engine;
  localparam int NOUT = 150;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int errors = 0;
  int img [6][6];
  int ker [6][4];
  int exp_q [NOUT];
  typedef struct {
    int pix;
    int k0, k1, k2, k3;
    int expv;
  } vec_t;
  vec_t tbl [7];
  conv2x2_stream_if bus ();
  conv2x2_stream_engine dut (.clk(clk), .rst(rst), .s(bus));
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask
  function automatic logic [17:0] pack_row(input int i);
    logic [17:0] v;
    for (int c = 0; c < 6; c++) v[3*c +: 3] = 3'(img[i][c]);
    return v;
  endfunction
  function automatic logic [11:0] pack_ker(input int i);
    logic [11:0] v;
    for (int j = 0; j < 4; j++) v[3*j +: 3] = 3'(ker[i][j]);
    return v;
  endfunction
  task automatic model();
    for (int n = 0; n < NOUT; n++) begin
      int k, r, c;
      k = n / 25;
      r = (n % 25) / 5;
      c = n % 5;
      exp_q[n] = img[r][c] * ker[k][0] + img[r][c+1] * ker[k][1] + img[r+1][c] * ker[k][2] + img[r+1][c+1] * ker[k][3];
    end
  endtask
  task automatic randomize_frame();
    for (int i = 0; i < 6; i++) begin
      for (int c = 0; c < 6; c++) img[i][c] = int'($urandom_range(7, 0));
      for (int j = 0; j < 4; j++) ker[i][j] = int'($urandom_range(7, 0));
    end
  endtask
  task automatic drive_junk(input bit en);
    bus.in_valid = en ? 1'($urandom) : 1'b0;
    bus.in_row = 18'($urandom);
    bus.in_kernel = 12'($urandom);
  endtask
  task automatic run_frame(input int abort_at, input bit junk);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("load_valid", int'(bus.out_valid), 0);
      chk("load_data", int'(bus.out_data), 0);
      bus.in_valid = 1'b1;
      bus.in_row = pack_row(i);
      bus.in_kernel = pack_ker(i);
    end
    @(negedge clk);
    chk("fill_valid", int'(bus.out_valid), 0);
    chk("fill_data", int'(bus.out_data), 0);
    drive_junk(junk);
    for (int j = 0; j < NOUT; j++) begin
      @(negedge clk);
      chk("out_valid", int'(bus.out_valid), 1);
      chk($sformatf("out_data[%0d]", j), int'(bus.out_data), exp_q[j]);
      if (j == abort_at) begin
        rst = 1'b1;
        @(negedge clk);
        chk("rst_valid", int'(bus.out_valid), 0);
        chk("rst_data", int'(bus.out_data), 0);
        rst = 1'b0;
        return;
      end
      drive_junk(junk && j < NOUT - 1);
    end
    @(negedge clk);
    chk("end_valid", int'(bus.out_valid), 0);
    chk("end_data", int'(bus.out_data), 0);
  endtask
  initial begin
    tbl[0] = '{7, 7, 7, 7, 7, 196};
    tbl[1] = '{0, 5, 3, 2, 1, 0};
    tbl[2] = '{1, 1, 2, 3, 4, 10};
    tbl[3] = '{2, 7, 0, 0, 7, 28};
    tbl[4] = '{5, 1, 1, 1, 1, 20};
    tbl[5] = '{3, 0, 7, 0, 0, 21};
    tbl[6] = '{6, 7, 7, 7, 7, 168};
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_row = '0;
    bus.in_kernel = '0;
    repeat (2) @(negedge clk);
    chk("reset_valid", int'(bus.out_valid), 0);
    chk("reset_data", int'(bus.out_data), 0);
    rst = 1'b0;
    for (int t = 0; t < 7; t++) begin
      for (int i = 0; i < 6; i++) begin
        for (int c = 0; c < 6; c++) img[i][c] = tbl[t].pix;
        ker[i] = '{tbl[t].k0, tbl[t].k1, tbl[t].k2, tbl[t].k3};
      end
      for (int n = 0; n < NOUT; n++) exp_q[n] = tbl[t].expv;
      run_frame(-1, 1'b0);
    end
    randomize_frame();
    for (int i = 0; i < 6; i++)
      for (int c = 0; c < 6; c++) img[i][c] = (i + c) % 7;
    ker[0] = '{1, 0, 0, 0};
    ker[5] = '{0, 0, 0, 1};
    model();
    run_frame(-1, 1'b0);
    randomize_frame();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_row = pack_row(i);
      bus.in_kernel = pack_ker(i);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (12) begin
      @(negedge clk);
      chk("partial_valid", int'(bus.out_valid), 0);
    end
    randomize_frame();
    model();
    run_frame(-1, 1'b0);
    randomize_frame();
    model();
    run_frame(70, 1'b0);
    randomize_frame();
    model();
    run_frame(-1, 1'b0);
    for (int f = 0; f < 4; f++) begin
      randomize_frame();
      model();
      run_frame(-1, f[0]);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
